alu_ctrl: RTL and testbench

Sequencing front-end for the 8-bit combinational ALU. It accepts one operation at a time over a valid/ready command port and drives registered operands and opcode into the ALU. It captures the ALU result and carry one cycle later, derives its own zero flag, and returns result plus flags over a valid/ready response port. It also keeps an accumulator for chained operations and a count of completed operations.

---
 rtl/alu_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: valid/ready sequencing front-end for the 8-bit ALU; registers
// operands/opcode, captures result+carry+zero, optional acc (ALU_CTRL_ACC_EN).
// Ports: clk, rst (sync, high); cmd_* in; alu_a/b/op out, alu_res/c in;
//        rsp_* out with rsp_ready in; op_count out (OP_CNT_W bits).
module alu_ctrl #(
  parameter int OP_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [7:0]          cmd_a,
  input  logic [7:0]          cmd_b,
  input  logic                cmd_use_acc,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_op,
  input  logic [7:0]          alu_res,
  input  logic                alu_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [7:0]          rsp_data,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [OP_CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic       legal;
  logic [7:0] op_a;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_op != 4'h0) && (cmd_op <= 4'hB);

`ifdef ALU_CTRL_ACC_EN
  logic [7:0] acc_q;

  assign op_a = cmd_use_acc ? acc_q : cmd_a;

  // acc follows every completed legal op, even before its response drains
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else if (state_q == EXEC) begin
      acc_q <= alu_res;
    end
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = cmd_use_acc;
  assign op_a           = cmd_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = legal ? EXEC : RESP;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 4'h0;
      rsp_data  <= 8'h00;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept && legal) begin
        alu_a  <= op_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      // illegal ops skip the ALU and answer straight away with err set
      if (accept && !legal) begin
        rsp_data  <= 8'h00;
        rsp_carry <= 1'b0;
        rsp_zero  <= 1'b0;
        rsp_err   <= 1'b1;
      end
      if (state_q == EXEC) begin
        rsp_data  <= alu_res;
        rsp_carry <= alu_c;
        rsp_zero  <= (alu_res == 8'h00);
        rsp_err   <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: scoreboard bench for alu_ctrl with a behavioural ALU
// attached and an arithmetic reference model for expected responses.
module tb_alu_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [7:0]   cmd_a;
  logic [7:0]   cmd_b;
  logic         cmd_use_acc;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [3:0]   alu_op;
  logic [7:0]   alu_res;
  logic         alu_c;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [7:0]   rsp_data;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_err;
  logic [W-1:0] op_count;
  logic [8:0]   alu_t;

  always #5 clk = ~clk;

  alu_ctrl #(.OP_CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // behavioural ALU: 9-bit result, bit 8 is carry/borrow
  always_comb begin
    alu_t = 9'h000;
    case (alu_op)
      4'h1: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      4'h2: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      4'h3: alu_t = {1'b0, alu_a} + 9'd1;
      4'h4: alu_t = {1'b0, alu_a} - 9'd1;
      4'h5: alu_t = {1'b0, alu_a | alu_b};
      4'h6: alu_t = {1'b0, alu_a & alu_b};
      4'h7: alu_t = {1'b0, alu_a ^ alu_b};
      4'h8: alu_t = {alu_a[0], 1'b0, alu_a[7:1]};
      4'h9: alu_t = {alu_a, 1'b0};
      4'hA: alu_t = {1'b0, ~alu_a};
      4'hB: alu_t = 9'h000 - {1'b0, alu_a};
      default: alu_t = 9'h000;
    endcase
  end
  assign alu_res = alu_t[7:0];
  assign alu_c   = alu_t[8];

  typedef struct {
    logic [7:0]   data;
    logic         carry;
    logic         zero;
    logic         err;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   acc_m;
  logic [W-1:0] cnt_m;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: integer arithmetic straight from the opcode meanings
  function automatic logic [8:0] ref_alu(int op, int a, int b);
    int r;
    bit c;
    r = 0;
    c = 0;
    case (op)
      1:  begin r = a + b; c = (r > 255); end
      2:  begin r = a - b; c = (r < 0); end
      3:  begin r = a + 1; c = (r > 255); end
      4:  begin r = a - 1; c = (r < 0); end
      5:  r = a | b;
      6:  r = a & b;
      7:  r = a ^ b;
      8:  begin r = a / 2; c = (a % 2) == 1; end
      9:  begin r = a * 2; c = (r > 255); end
      10: r = 255 - a;
      11: begin r = -a; c = (a != 0); end
      default: r = 0;
    endcase
    return {c, r[7:0]};
  endfunction

  // monitor: pops one expectation per response handshake
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %0h expected none",
                 rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_carry", rsp_carry, e.carry);
        check("rsp_zero", rsp_zero, e.zero);
        check("rsp_err", rsp_err, e.err);
        check("op_count", op_count, e.cnt);
      end
    end
  end

  task automatic send(logic [3:0] op, logic [7:0] a,
                      logic [7:0] b, logic ua);
    logic       legal;
    logic [3:0] prev_op;
    logic [8:0] r;
    logic [7:0] ea;
    exp_t       e;
    int         n;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    legal   = (op >= 1) && (op <= 11);
    prev_op = alu_op;
    ea      = a;
`ifdef ALU_CTRL_ACC_EN
    if (ua) ea = acc_m;
`endif
    if (legal) begin
      r       = ref_alu(int'(op), int'(ea), int'(b));
      cnt_m   = cnt_m + 1'b1;
      acc_m   = r[7:0];
      e.data  = r[7:0];
      e.carry = r[8];
      e.zero  = (r[7:0] == 8'h00);
      e.err   = 1'b0;
    end else begin
      e.data  = 8'h00;
      e.carry = 1'b0;
      e.zero  = 1'b0;
      e.err   = 1'b1;
    end
    e.cnt = cnt_m;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (legal) begin
      check("alu_op_latch", alu_op, op);
      check("alu_a_latch", alu_a, ea);
      check("alu_b_latch", alu_b, b);
      check("rsp_valid_early", rsp_valid, 0);
      @(negedge clk);
      check("rsp_valid_lat2", rsp_valid, 1);
    end else begin
      check("rsp_valid_lat1", rsp_valid, 1);
      check("alu_op_hold", alu_op, prev_op);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cmd_ready && !rsp_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ready && !rsp_valid))
      check("idle_timeout", cmd_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 4'h0;
    cmd_a       = 8'h00;
    cmd_b       = 8'h00;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b1;
    acc_m       = 8'h00;
    cmd_m_init();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_op_count", op_count, 0);

    send(4'h1, 8'hF0, 8'h20, 1'b0);
    wait_idle();
    send(4'h2, 8'h05, 8'h05, 1'b0);
    wait_idle();
    send(4'h2, 8'h00, 8'h01, 1'b0);
    wait_idle();
    send(4'hC, 8'h12, 8'h00, 1'b0);
    wait_idle();

    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(4'h7, 8'hAA, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", rsp_data, 8'h55);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_after", cmd_ready, 1);
    check("bp_valid_after", rsp_valid, 0);

    send(4'h1, 8'h7F, 8'h01, 1'b0);
    wait_idle();
    send(4'h3, 8'h00, 8'h00, 1'b1);
`ifdef ALU_CTRL_ACC_EN
    check("acc_inc", rsp_data, 8'h81);
`else
    check("acc_inc", rsp_data, 8'h01);
`endif
    wait_idle();

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_m_init();
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = 4'h1;
    cmd_a       = 8'h01;
    cmd_b       = 8'h01;
    cmd_use_acc = 1'b0;
    check("exec_rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("exec_rst_op", alu_op, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("exec_rst_valid", rsp_valid, 0);
      check("exec_rst_cnt", op_count, 0);
      check("exec_rst_alu_op", alu_op, 0);
    end
    send(4'h1, 8'h03, 8'h04, 1'b0);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom),
           8'($urandom), 1'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  task automatic cmd_m_init();
    cnt_m = '0;
    acc_m = 8'h00;
    sb.delete();
  endtask

endmodule
